bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 135 +++++++++++++
 tb/tb_bus_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Sequences one CPU cycle's data access and instruction fetch onto a single
// downstream memory port. A data access always goes before the fetch.
module bus_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] iaddr,
    output logic [31:0] iin,
    input  logic [1:0]  drw,
    input  logic [31:0] daddr,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        ireq_q;
    logic [1:0]  drw_q;
    logic [31:0] iaddr_q;

    logic data_req;
    logic timeout_hit;
    logic acc_end;

    // Handshake: mem_req is held high from the entry edge of an access state
    // until the edge on which mem_ack is sampled high (or the wait counter
    // expires); mem_ack outside an access state carries no meaning.
    assign data_req    = (drw == 2'b01) || (drw == 2'b10);
    assign timeout_hit = !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));
    assign acc_end     = mem_ack || timeout_hit;

    assign fsm_state = state;

    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            IDLE:         cpu_stall = data_req || i_req;
            D_ACC, I_ACC: cpu_stall = 1'b1;
            default:      cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            ireq_q    <= 1'b0;
            drw_q     <= 2'b00;
            iaddr_q   <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            din       <= 32'd0;
            iin       <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req || i_req) begin
                        ireq_q   <= i_req;
                        drw_q    <= drw;
                        iaddr_q  <= iaddr;
                        wait_cnt <= 8'd0;
                        mem_req  <= 1'b1;
                    end
                    if (data_req) begin
                        state     <= D_ACC;
                        mem_we    <= (drw == 2'b10);
                        mem_addr  <= {daddr[31:2], 2'b00};
                        mem_wdata <= dout;
                    end else if (i_req) begin
                        state    <= I_ACC;
                        mem_we   <= 1'b0;
                        mem_addr <= {iaddr[31:2], 2'b00};
                    end
                end
                D_ACC: begin
                    if (acc_end) begin
                        // A timed-out read returns zero rather than stale data.
                        if (drw_q == 2'b01)
                            din <= mem_ack ? mem_rdata : 32'd0;
                        if (timeout_hit)
                            bus_err <= 1'b1;
                        mem_we <= 1'b0;
                        if (ireq_q) begin
                            state    <= I_ACC;
                            mem_addr <= {iaddr_q[31:2], 2'b00};
                            wait_cnt <= 8'd0;
                        end else begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                I_ACC: begin
                    if (acc_end) begin
                        iin <= mem_ack ? mem_rdata : 32'd0;
                        if (timeout_hit)
                            bus_err <= 1'b1;
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: fetch, read+fetch, write, timeout,
// ack-on-timeout, stray acks and reset during an access.
module tb_bus_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_D_ACC = 2'd1;
    localparam logic [1:0] S_I_ACC = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] iaddr;
    logic [31:0] iin;
    logic [1:0]  drw;
    logic [31:0] daddr;
    logic [31:0] dout;
    logic [31:0] din;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_din;
    logic [31:0] exp_iin;

    bus_sequencer #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .iaddr     (iaddr),
        .iin       (iin),
        .drw       (drw),
        .daddr     (daddr),
        .dout      (dout),
        .din       (din),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req     = 1'b0;
        iaddr     = 32'd0;
        drw       = 2'b00;
        daddr     = 32'd0;
        dout      = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        exp_din = 32'd0;
        exp_iin = 32'd0;
        repeat (2) @(negedge clk);

        check("rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_iin", iin, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        rst = 1'b0;

        // Idle: no requests for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_stall", {31'd0, cpu_stall}, 32'd0);
            check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        end

        // Fetch only, ack two cycles after mem_req rises.
        i_req = 1'b1;
        iaddr = 32'h100;
        #1;
        check("f_stall_idle", {31'd0, cpu_stall}, 32'd1);
        cyc();
        check("f_state", {30'd0, fsm_state}, {30'd0, S_I_ACC});
        check("f_mem_req", {31'd0, mem_req}, 32'd1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_we", {31'd0, mem_we}, 32'd0);
        cyc();
        check("f_mem_req_wait", {31'd0, mem_req}, 32'd1);
        check("f_stall_wait", {31'd0, cpu_stall}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        cyc();
        mem_ack = 1'b0;
        exp_iin = 32'hDEADBEEF;
        check("f_done_state", {30'd0, fsm_state}, {30'd0, S_DONE});
        check("f_iin", iin, exp_iin);
        check("f_done_stall", {31'd0, cpu_stall}, 32'd0);
        check("f_done_mem_req", {31'd0, mem_req}, 32'd0);
        clear_inputs();
        cyc();
        check("f_back_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});

        // Read + fetch; iaddr changes mid-access must be ignored.
        drw = 2'b01;
        daddr = 32'h2003;
        i_req = 1'b1;
        iaddr = 32'h10;
        cyc();
        check("rf_state_d", {30'd0, fsm_state}, {30'd0, S_D_ACC});
        check("rf_addr_d", mem_addr, 32'h2000);
        check("rf_we_d", {31'd0, mem_we}, 32'd0);
        iaddr = 32'h999;
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A50001;
        cyc();
        mem_ack = 1'b0;
        exp_din = 32'hA5A50001;
        check("rf_state_i", {30'd0, fsm_state}, {30'd0, S_I_ACC});
        check("rf_din", din, exp_din);
        check("rf_addr_i", mem_addr, 32'h10);
        check("rf_req_i", {31'd0, mem_req}, 32'd1);
        check("rf_stall_i", {31'd0, cpu_stall}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BADF00D;
        cyc();
        mem_ack = 1'b0;
        exp_iin = 32'h0BADF00D;
        check("rf_iin", iin, exp_iin);
        check("rf_din_hold", din, exp_din);
        check("rf_done_stall", {31'd0, cpu_stall}, 32'd0);
        clear_inputs();
        cyc();

        // Write: din must be untouched.
        drw = 2'b10;
        daddr = 32'h44;
        dout = 32'h12345678;
        cyc();
        check("w_we", {31'd0, mem_we}, 32'd1);
        check("w_wdata", mem_wdata, 32'h12345678);
        check("w_addr", mem_addr, 32'h44);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        cyc();
        mem_ack = 1'b0;
        check("w_din_hold", din, exp_din);
        check("w_done_we", {31'd0, mem_we}, 32'd0);
        check("w_done_req", {31'd0, mem_req}, 32'd0);
        check("w_bus_err", {31'd0, bus_err}, 32'd0);
        clear_inputs();
        cyc();

        // Ack arriving on the last allowed wait cycle is a success.
        drw = 2'b01;
        daddr = 32'h90;
        cyc();
        repeat (3) cyc();
        check("ta_req_last", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h00000077;
        cyc();
        mem_ack = 1'b0;
        exp_din = 32'h00000077;
        check("ta_state", {30'd0, fsm_state}, {30'd0, S_DONE});
        check("ta_din", din, exp_din);
        check("ta_bus_err", {31'd0, bus_err}, 32'd0);
        clear_inputs();
        cyc();

        // Timeout on a read with TIMEOUT=4.
        drw = 2'b01;
        daddr = 32'h80;
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("to_req_wait", {31'd0, mem_req}, 32'd1);
            cyc();
        end
        exp_din = 32'd0;
        check("to_req_drop", {31'd0, mem_req}, 32'd0);
        check("to_state", {30'd0, fsm_state}, {30'd0, S_DONE});
        check("to_din", din, exp_din);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        clear_inputs();
        cyc();

        // Stray ack in IDLE is ignored; bus_err stays set after a good fetch.
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        cyc();
        mem_ack = 1'b0;
        check("stray_din", din, exp_din);
        check("stray_iin", iin, exp_iin);
        check("stray_req", {31'd0, mem_req}, 32'd0);
        i_req = 1'b1;
        iaddr = 32'h204;
        cyc();
        mem_ack = 1'b1;
        mem_rdata = 32'h13579BDF;
        cyc();
        mem_ack = 1'b0;
        exp_iin = 32'h13579BDF;
        check("sticky_iin", iin, exp_iin);
        check("sticky_bus_err", {31'd0, bus_err}, 32'd1);
        clear_inputs();
        cyc();

        // Reset during a data access, then a late ack.
        drw = 2'b01;
        daddr = 32'h300;
        cyc();
        check("rm_state_d", {30'd0, fsm_state}, {30'd0, S_D_ACC});
        drw = 2'b00;
        rst = 1'b1;
        #1;
        check("rm_req", {31'd0, mem_req}, 32'd0);
        check("rm_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
        check("rm_addr", mem_addr, 32'd0);
        check("rm_wdata", mem_wdata, 32'd0);
        check("rm_din", din, 32'd0);
        check("rm_iin", iin, 32'd0);
        check("rm_bus_err", {31'd0, bus_err}, 32'd0);
        check("rm_stall", {31'd0, cpu_stall}, 32'd0);
        cyc();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        cyc();
        mem_ack = 1'b0;
        check("late_ack_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
        check("late_ack_din", din, 32'd0);
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
